seq_detector_param: RTL and testbench

//   Parametrised Mealy serial-sequence detector, successor to the fixed "0110" detector.
//   - Detects any N-bit pattern on a 1-bit serial stream; overlap/non-overlap selectable at run time.
//   - Qualified by a valid strobe; keeps a saturating match counter.
//   - Sits on a serial input after the bit sampler; z feeds the downstream event/IRQ logic.

---
 rtl/seqdet_pkg.sv | 75 +++++++
 rtl/seqdet_fallback.sv | 41 ++++
 rtl/seq_detector_param.sv | 94 +++++++++
 tb/tb_seq_detector_param.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seqdet_pkg.sv
// rtl/seqdet_pkg.sv - shared types and next-state function for the sequence detector
// Contents:
//   SEQDET_MAX_N  largest supported pattern length
//   clog2         ceiling log2, minimum 1 (state register width)
//   seqdet_next   one KMP step: (pattern, n, s, x, overlap) -> {next state, full match}
package seqdet_pkg;

    localparam int SEQDET_MAX_N  = 16;
    localparam int SEQDET_SW_MAX = 5;

    typedef struct packed {
        logic [SEQDET_SW_MAX-1:0] next_s;
        logic                     match;
    } seqdet_step_t;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

    // pattern is right-aligned: pattern[n-1] is the first bit received.
    // Returns S=0 for any out-of-range state so stray states self-recover.
    function automatic seqdet_step_t seqdet_next(
        input logic [SEQDET_MAX_N-1:0] pattern,
        input int                      n,
        input int                      s,
        input logic                    x,
        input logic                    overlap
    );
        seqdet_step_t            res;
        logic [SEQDET_MAX_N-1:0] pb;   // pattern in arrival order
        logic [SEQDET_MAX_N-1:0] w;    // matched prefix plus x, arrival order
        logic                    full;
        logic                    ok;
        int                      len;
        int                      kmax;
        int                      best;
        res  = '0;
        pb   = '0;
        w    = '0;
        full = 1'b0;
        ok   = 1'b0;
        best = 0;
        if (n >= 2 && n <= SEQDET_MAX_N && s >= 0 && s < n) begin
            for (int i = 0; i < SEQDET_MAX_N; i++) begin
                if (i < n) pb[i] = pattern[4'(n - 1 - i)];
            end
            full = (s == n - 1) && (x == pattern[0]);
            len  = s + 1;
            // On a full match w is the whole pattern, so the same search
            // with k < n yields its longest proper border.
            kmax = full ? n - 1 : len;
            for (int i = 0; i < SEQDET_MAX_N; i++) begin
                if (i < len) w[i] = (i < s) ? pb[i] : x;
            end
            for (int k = 1; k <= SEQDET_MAX_N; k++) begin
                if (k <= kmax) begin
                    ok = 1'b1;
                    for (int j = 0; j < SEQDET_MAX_N; j++) begin
                        if (j < k && w[4'(len - k + j)] != pb[j]) ok = 1'b0;
                    end
                    if (ok) best = k;
                end
            end
            res.match  = full;
            res.next_s = (full && !overlap) ? '0 : SEQDET_SW_MAX'(best);
        end
        return res;
    endfunction

endpackage

// File: rtl/seqdet_fallback.sv
// rtl/seqdet_fallback.sv - combinational next-state / match unit
// Ports:
//   pattern     in  N   pattern, bit N-1 received first
//   state       in  SW  bits currently matched
//   x, x_valid  in  1   serial bit and its qualifier
//   overlap     in  1   keep the border after a full match
//   next_state  out SW  state for the next clock (holds when x_valid=0)
//   match       out 1   full match on this bit
module seqdet_fallback
    import seqdet_pkg::*;
#(
    parameter int N  = 4,
    parameter int SW = clog2(N)
) (
    input  logic [N-1:0]  pattern,
    input  logic [SW-1:0] state,
    input  logic          x,
    input  logic          x_valid,
    input  logic          overlap,
    output logic [SW-1:0] next_state,
    output logic          match
);

    logic [SEQDET_MAX_N-1:0] pat_ext;
    seqdet_step_t            step;

    // With a constant pattern the whole search folds to a lookup table.
    always_comb begin
        pat_ext          = '0;
        pat_ext[N-1:0]   = pattern;
        step             = seqdet_next(pat_ext, N, int'(state), x, overlap);
        if (x_valid) begin
            next_state = SW'(step.next_s);
            match      = step.match;
        end else begin
            next_state = state;
            match      = 1'b0;
        end
    end

endmodule

// File: rtl/seq_detector_param.sv
// rtl/seq_detector_param.sv - parametrised Mealy serial-sequence detector
// Optional feature macro: SEQDET_PROG_EN (run-time programmable pattern).
// Ports:
//   clk, reset_n   clock, asynchronous active-low reset
//   x, x_valid     serial bit and its qualifier
//   overlap        1 = overlapping detection, 0 = restart after a match
//   cnt_clr        synchronous clear of match_count (wins over increment)
//   z              Mealy match pulse, same cycle as the last pattern bit
//   match_count    saturating match counter
//   pat_wr         [SEQDET_PROG_EN] load pat_data into the pattern register
//   pat_data       [SEQDET_PROG_EN] new pattern, bit N-1 received first
module seq_detector_param
    import seqdet_pkg::*;
#(
    parameter int           N       = 4,
    parameter logic [N-1:0] PATTERN = 4'b0110,
    parameter int           CNT_W   = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             x,
    input  logic             x_valid,
    input  logic             overlap,
    input  logic             cnt_clr,
    output logic             z,
    output logic [CNT_W-1:0] match_count
`ifdef SEQDET_PROG_EN
    ,
    input  logic             pat_wr,
    input  logic [N-1:0]     pat_data
`endif
);

    localparam int SW = clog2(N);

    logic [SW-1:0] state;
    logic [SW-1:0] state_d;
    logic [SW-1:0] step_state;
    logic          step_match;
    logic [N-1:0]  pattern;
    logic          wr;

`ifdef SEQDET_PROG_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pattern <= PATTERN;
        end else if (pat_wr) begin
            pattern <= pat_data;
        end
    end
    assign wr = pat_wr;
`else
    assign pattern = PATTERN;
    assign wr      = 1'b0;
`endif

    seqdet_fallback #(.N(N), .SW(SW)) u_fallback (
        .pattern    (pattern),
        .state      (state),
        .x          (x),
        .x_valid    (x_valid),
        .overlap    (overlap),
        .next_state (step_state),
        .match      (step_match)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= '0;
        end else begin
            state <= state_d;
        end
    end

    // A pattern load restarts the search and discards the bit on x.
    always_comb begin
        state_d = wr ? '0 : step_state;
    end

    always_comb begin
        z = step_match & ~wr;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            match_count <= '0;
        end else if (cnt_clr) begin
            match_count <= '0;
        end else if (z && match_count != {CNT_W{1'b1}}) begin
            match_count <= match_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_seq_detector_param.sv
// tb/tb_seq_detector_param.sv - self-checking bench for seq_detector_param
module tb_seq_detector_param;
    import seqdet_pkg::*;

    localparam logic [15:0] PBASE = 16'hB5A3;

    logic       clk;
    logic       reset_n;
    logic       x;
    logic       x_valid;
    logic       overlap;
    logic       cnt_clr;
    logic       pat_wr;
    logic       z;
    logic       z_sat;
    logic [7:0] cnt;
    logic [1:0] cnt_sat;
    logic       rz [2:16];
    logic [7:0] rc [2:16];
`ifdef SEQDET_PROG_EN
    logic [3:0] pat_data;
`endif

    int   n_checks;
    int   n_fail;
    int   m_cnt;
    int   m_sat;
    logic q_z [$];
    logic rq  [$];

    seq_detector_param #(.N(4), .PATTERN(4'b0110), .CNT_W(8)) dut (
        .clk(clk), .reset_n(reset_n), .x(x), .x_valid(x_valid), .overlap(overlap),
        .cnt_clr(cnt_clr), .z(z), .match_count(cnt)
`ifdef SEQDET_PROG_EN
        , .pat_wr(pat_wr), .pat_data(pat_data)
`endif
    );

    seq_detector_param #(.N(4), .PATTERN(4'b0110), .CNT_W(2)) dut_sat (
        .clk(clk), .reset_n(reset_n), .x(x), .x_valid(x_valid), .overlap(overlap),
        .cnt_clr(cnt_clr), .z(z_sat), .match_count(cnt_sat)
`ifdef SEQDET_PROG_EN
        , .pat_wr(pat_wr), .pat_data(pat_data)
`endif
    );

    genvar g;
    generate
        for (g = 2; g <= 16; g++) begin : gen_n
            seq_detector_param #(.N(g), .PATTERN(PBASE[g-1:0]), .CNT_W(8)) u_dut (
                .clk(clk), .reset_n(reset_n), .x(x), .x_valid(x_valid), .overlap(overlap),
                .cnt_clr(1'b0), .z(rz[g]), .match_count(rc[g])
`ifdef SEQDET_PROG_EN
                , .pat_wr(1'b0), .pat_data(PBASE[g-1:0])
`endif
            );
        end
    endgenerate

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic send_bit(input logic xb, input logic vb, input logic clr,
                            input logic wr, input logic exp_z);
        logic e;
        @(negedge clk);
        x = xb; x_valid = vb; cnt_clr = clr; pat_wr = wr;
        q_z.push_back(exp_z);
        #2;
        e = q_z.pop_front();
        n_checks++;
        if (z !== e) begin
            n_fail++; $display("FAIL z: got %b expected %b", z, e);
        end
        n_checks++;
        if (z_sat !== e) begin
            n_fail++; $display("FAIL z_sat: got %b expected %b", z_sat, e);
        end
        if (clr) begin
            m_cnt = 0; m_sat = 0;
        end else if (e) begin
            if (m_cnt != 255) m_cnt++;
            if (m_sat != 3) m_sat++;
        end
        @(posedge clk);
        #1;
        x_valid = 1'b0; cnt_clr = 1'b0; pat_wr = 1'b0;
        n_checks++;
        if (int'(cnt) != m_cnt) begin
            n_fail++; $display("FAIL match_count: got %0d expected %0d", cnt, m_cnt);
        end
        n_checks++;
        if (int'(cnt_sat) != m_sat) begin
            n_fail++; $display("FAIL match_count_sat: got %0d expected %0d", cnt_sat, m_sat);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0; x_valid = 1'b0; cnt_clr = 1'b0; pat_wr = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        m_cnt = 0; m_sat = 0;
    endtask

    task automatic test_reset();
        #3;
        n_checks++;
        if (z !== 1'b0) begin n_fail++; $display("FAIL reset_z: got %b expected 0", z); end
        n_checks++;
        if (cnt !== 8'd0) begin n_fail++; $display("FAIL reset_count: got %0d expected 0", cnt); end
        n_checks++;
        if (cnt_sat !== 2'd0) begin n_fail++; $display("FAIL reset_count_sat: got %0d expected 0", cnt_sat); end
        n_checks++;
        if (dut.state !== 2'd0) begin n_fail++; $display("FAIL reset_state: got %0d expected 0", dut.state); end
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_overlap();
        logic [6:0] s_bits = 7'b0110110;
        logic [6:0] e_bits = 7'b0001001;
        do_reset();
        overlap = 1'b1;
        for (int i = 6; i >= 0; i--) send_bit(s_bits[i], 1'b1, 1'b0, 1'b0, e_bits[i]);
        n_checks++;
        if (cnt !== 8'd2) begin n_fail++; $display("FAIL overlap_count: got %0d expected 2", cnt); end
        n_checks++;
        if (dut.state !== 2'd1) begin n_fail++; $display("FAIL overlap_state: got %0d expected 1", dut.state); end
    endtask

    task automatic test_non_overlap();
        logic [6:0] s_bits = 7'b0110110;
        logic [6:0] e_bits = 7'b0001000;
        do_reset();
        overlap = 1'b0;
        for (int i = 6; i >= 0; i--) send_bit(s_bits[i], 1'b1, 1'b0, 1'b0, e_bits[i]);
        n_checks++;
        if (cnt !== 8'd1) begin n_fail++; $display("FAIL nonoverlap_count: got %0d expected 1", cnt); end
        n_checks++;
        if (dut.state !== 2'd1) begin n_fail++; $display("FAIL nonoverlap_state: got %0d expected 1", dut.state); end
        overlap = 1'b1;
    endtask

    task automatic test_gaps();
        logic [3:0] s_bits = 4'b0110;
        logic [3:0] e_bits = 4'b0001;
        logic [1:0] e_state [4] = '{2'd1, 2'd2, 2'd3, 2'd1};
        do_reset();
        overlap = 1'b1;
        for (int i = 0; i < 4; i++) begin
            send_bit(s_bits[3-i], 1'b1, 1'b0, 1'b0, e_bits[3-i]);
            // x=0 while idle would complete the pattern from S=3 if it leaked through
            for (int k = 0; k < 3; k++) send_bit(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            n_checks++;
            if (dut.state !== e_state[i]) begin
                n_fail++; $display("FAIL gap_state[%0d]: got %0d expected %0d", i, dut.state, e_state[i]);
            end
        end
    endtask

    task automatic test_reset_mid();
        send_bit(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        send_bit(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        send_bit(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        n_checks++;
        if (dut.state !== 2'd0) begin n_fail++; $display("FAIL async_reset_state: got %0d expected 0", dut.state); end
        n_checks++;
        if (cnt !== 8'd0) begin n_fail++; $display("FAIL async_reset_count: got %0d expected 0", cnt); end
        m_cnt = 0; m_sat = 0;
        @(negedge clk);
        reset_n = 1'b1;
        send_bit(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        n_checks++;
        if (dut.state !== 2'd1) begin n_fail++; $display("FAIL post_reset_state: got %0d expected 1", dut.state); end
    endtask

    task automatic test_saturation();
        logic [15:0] s_bits = 16'b0110110110110110;
        logic [15:0] e_bits = 16'b0001001001001001;
        do_reset();
        overlap = 1'b1;
        for (int i = 15; i >= 0; i--) send_bit(s_bits[i], 1'b1, 1'b0, 1'b0, e_bits[i]);
        n_checks++;
        if (cnt_sat !== 2'd3) begin n_fail++; $display("FAIL saturate_count: got %0d expected 3", cnt_sat); end
        n_checks++;
        if (cnt !== 8'd5) begin n_fail++; $display("FAIL wide_count: got %0d expected 5", cnt); end
    endtask

    task automatic test_clear_wins();
        logic [15:0] s_bits = 16'b0110110110110110;
        logic [15:0] e_bits = 16'b0001001001001001;
        do_reset();
        overlap = 1'b1;
        for (int i = 15; i >= 0; i--)
            send_bit(s_bits[i], 1'b1, (i == 0), 1'b0, e_bits[i]);
        n_checks++;
        if (cnt_sat !== 2'd0) begin n_fail++; $display("FAIL clear_wins_sat: got %0d expected 0", cnt_sat); end
        n_checks++;
        if (cnt !== 8'd0) begin n_fail++; $display("FAIL clear_wins: got %0d expected 0", cnt); end
    endtask

`ifdef SEQDET_PROG_EN
    task automatic test_prog();
        logic [6:0] s_bits = 7'b1011011;
        logic [6:0] e_bits = 7'b0001001;
        do_reset();
        overlap = 1'b1;
        send_bit(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        send_bit(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        send_bit(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        // The 0 here would complete the old pattern; the load must swallow it.
        pat_data = 4'b1011;
        send_bit(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        n_checks++;
        if (dut.state !== 2'd0) begin n_fail++; $display("FAIL prog_state: got %0d expected 0", dut.state); end
        for (int i = 6; i >= 0; i--) send_bit(s_bits[i], 1'b1, 1'b0, 1'b0, e_bits[i]);
        n_checks++;
        if (cnt !== 8'd2) begin n_fail++; $display("FAIL prog_count: got %0d expected 2", cnt); end
        pat_data = 4'b0110;
        send_bit(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    endtask
`endif

    task automatic test_random();
        int           rs [2:16];
        int           rcm [2:16];
        int           pos;
        logic [15:0]  pm;
        seqdet_step_t r;
        logic         e;
        do_reset();
        for (int k = 2; k <= 16; k++) begin rs[k] = 0; rcm[k] = 0; end
        pos = 15;
        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            // Mostly replay PBASE cyclically so every pattern length gets hits.
            x       = ($urandom_range(0, 9) == 0) ? ~PBASE[4'(pos)] : PBASE[4'(pos)];
            x_valid = ($urandom_range(0, 3) != 0);
            overlap = $urandom_range(0, 1) != 0;
            if (x_valid) pos = (pos == 0) ? 15 : pos - 1;
            for (int k = 2; k <= 16; k++) begin
                pm = PBASE & 16'((32'd1 << k) - 32'd1);
                r  = seqdet_next(pm, k, rs[k], x, overlap);
                e  = x_valid & r.match;
                rq.push_back(e);
                if (x_valid && !pat_wr) rs[k] = int'(r.next_s);
                if (e && rcm[k] != 255) rcm[k]++;
            end
            #2;
            for (int k = 2; k <= 16; k++) begin
                e = rq.pop_front();
                n_checks++;
                if (rz[k] !== e) begin
                    n_fail++; $display("FAIL random_z n=%0d cycle %0d: got %b expected %b", k, c, rz[k], e);
                end
            end
        end
        @(posedge clk);
        #1;
        x_valid = 1'b0;
        for (int k = 2; k <= 16; k++) begin
            n_checks++;
            if (int'(rc[k]) != rcm[k]) begin
                n_fail++; $display("FAIL random_count n=%0d: got %0d expected %0d", k, rc[k], rcm[k]);
            end
        end
    endtask

    initial begin
        n_checks = 0; n_fail = 0; m_cnt = 0; m_sat = 0;
        reset_n = 1'b0; x = 1'b0; x_valid = 1'b0; overlap = 1'b1;
        cnt_clr = 1'b0; pat_wr = 1'b0;
`ifdef SEQDET_PROG_EN
        pat_data = 4'b0110;
`endif
        test_reset();
        test_overlap();
        test_non_overlap();
        test_gaps();
        test_reset_mid();
        test_saturation();
        test_clear_wins();
`ifdef SEQDET_PROG_EN
        test_prog();
`endif
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
